// File: rtl/rob_reorder_ctrl.sv
// ============================================================================
// rob_reorder_ctrl : reorder-buffer controller. Allocates slots in order, accepts
//                    writebacks in any order, retires in order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_reorder_ctrl #(
  parameter int p_depth    = 16,
  parameter int p_ptrwidth = 4,
  parameter int p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_val,
  output logic                  alloc_rdy,
  output logic [p_ptrwidth-1:0] alloc_ptr,
  input  logic                  wb_val,
  input  logic [p_ptrwidth-1:0] wb_ptr,
  input  logic [p_bitwidth-1:0] wb_data,
  output logic                  wb_err,
  output logic                  commit_val,
  input  logic                  commit_rdy,
  output logic [p_ptrwidth-1:0] commit_ptr,
  output logic [p_bitwidth-1:0] commit_data,
  input  logic                  flush,
  output logic [p_ptrwidth:0]   count
);

  localparam logic [p_ptrwidth:0] c_full_count = (p_ptrwidth + 1)'(p_depth);

  logic [p_ptrwidth-1:0] head;
  logic [p_ptrwidth-1:0] tail;
  logic [p_depth-1:0]    occ;
  logic [p_bitwidth-1:0] data_mem [p_depth];

  logic                  alloc_fire;
  logic                  commit_fire;
  logic [p_ptrwidth-1:0] wb_offset;
  logic                  wb_allocated;
  logic                  wb_legal;

  // Outputs come only from registered state.
  assign alloc_rdy   = (count != c_full_count);
  assign alloc_ptr   = tail;
  assign commit_val  = (count != '0) && occ[head];
  assign commit_ptr  = head;
  assign commit_data = data_mem[head];

  assign alloc_fire  = alloc_val && alloc_rdy;
  assign commit_fire = commit_val && commit_rdy;

  // A slot is live when its distance from head (mod depth) is below count.
  assign wb_offset    = wb_ptr - head;
  assign wb_allocated = ({1'b0, wb_offset} < count);
  assign wb_legal     = wb_allocated && !occ[wb_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      occ    <= '0;
      wb_err <= 1'b0;
      for (int i = 0; i < p_depth; i++) begin
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      // Payloads are intentionally kept; only bookkeeping is discarded.
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      occ    <= '0;
      wb_err <= 1'b0;
    end else begin
      wb_err <= wb_val && !wb_legal;

      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end

      if (commit_fire) begin
        head      <= head + 1'b1;
        occ[head] <= 1'b0;
      end

      // A legal writeback never targets an occupied head, so it cannot collide with a commit.
      if (wb_val && wb_legal) begin
        occ[wb_ptr]      <= 1'b1;
        data_mem[wb_ptr] <= wb_data;
      end

      if (alloc_fire && !commit_fire) begin
        count <= count + 1'b1;
      end else if (!alloc_fire && commit_fire) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
